// File: rtl/sqrt_fp_iterative.sv
// Parametrised floating-point square root: restoring digit-by-digit root on the
// significand (one bit per cycle) followed by round-to-nearest-even.
module sqrt_fp_iterative #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    localparam int W     = 1 + EXP_W + MANT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sqrt,
    output logic         invalid,
    output logic         inexact
);

    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int RW   = 2 * (MANT_W + 2);
    localparam int REMW = MANT_W + 4;
    localparam int QW   = MANT_W + 2;
    localparam int CW   = $clog2(MANT_W + 2);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, ROUND} state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     rad, rad_nxt;
    logic [REMW-1:0]   rem, rem_nxt;
    logic [QW-1:0]     root, root_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [EXP_W-1:0]  rexp, rexp_nxt;
    logic [W-1:0]      sqrt_nxt;
    logic              invalid_nxt, inexact_nxt, done_nxt;

    // Operand fields and classification
    logic              sgn;
    logic [EXP_W-1:0]  ex;
    logic [MANT_W-1:0] fr;
    logic              is_special, spec_inv;
    logic [W-1:0]      spec_res;
    logic [EXP_W:0]    exp_sum;
    logic              e_odd;
    logic [EXP_W-1:0]  exp_in;

    assign sgn = a[W-1];
    assign ex  = a[W-2:MANT_W];
    assign fr  = a[MANT_W-1:0];

    // floor((exp-BIAS)/2)+BIAS == (exp+BIAS)>>1; parity of exp+BIAS matches exp-BIAS
    assign exp_sum = {1'b0, ex} + (EXP_W+1)'(BIAS);
    assign exp_in  = exp_sum[EXP_W:1];
    assign e_odd   = exp_sum[0];

    always_comb begin
        is_special = 1'b1;
        spec_inv   = 1'b0;
        spec_res   = QNAN;
        if (ex == '0) begin
            spec_res = {sgn, {(W-1){1'b0}}};
        end else if (ex == '1 && fr != '0) begin
            spec_inv = ~fr[MANT_W-1];
        end else if (sgn) begin
            spec_inv = 1'b1;
        end else if (ex == '1) begin
            spec_res = a;
        end else begin
            is_special = 1'b0;
        end
    end

    // Iteration step and rounding datapath
    logic [REMW-1:0]   rem_sh, trial;
    logic              ge;
    logic              guard, sticky, up;
    logic [MANT_W:0]   mant_sum;
    logic [EXP_W-1:0]  exp_r;

    assign rem_sh   = {rem[REMW-3:0], rad[RW-1 -: 2]};
    assign trial    = {root, 2'b01};
    assign ge       = (rem_sh >= trial);
    assign guard    = root[0];
    assign sticky   = (rem != '0);
    assign up       = guard & (sticky | root[1]);
    assign mant_sum = {1'b0, root[MANT_W:1]} + (MANT_W+1)'(up);
    assign exp_r    = mant_sum[MANT_W] ? rexp + EXP_W'(1) : rexp;

    assign busy = (state == ITER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            cnt     <= '0;
            rexp    <= '0;
            sqrt    <= '0;
            invalid <= 1'b0;
            inexact <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rad     <= rad_nxt;
            rem     <= rem_nxt;
            root    <= root_nxt;
            cnt     <= cnt_nxt;
            rexp    <= rexp_nxt;
            sqrt    <= sqrt_nxt;
            invalid <= invalid_nxt;
            inexact <= inexact_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rad_nxt     = rad;
        rem_nxt     = rem;
        root_nxt    = root;
        cnt_nxt     = cnt;
        rexp_nxt    = rexp;
        sqrt_nxt    = sqrt;
        invalid_nxt = invalid;
        inexact_nxt = inexact;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_special) begin
                        sqrt_nxt    = spec_res;
                        invalid_nxt = spec_inv;
                        inexact_nxt = 1'b0;
                        done_nxt    = 1'b1;
                    end else begin
                        state_nxt = ITER;
                        rad_nxt   = e_odd ? {1'b1, fr, {(MANT_W+3){1'b0}}}
                                          : {2'b01, fr, {(MANT_W+2){1'b0}}};
                        rem_nxt   = '0;
                        root_nxt  = '0;
                        cnt_nxt   = CW'(MANT_W + 1);
                        rexp_nxt  = exp_in;
                    end
                end
            end
            ITER: begin
                rad_nxt = rad << 2;
                if (ge) begin
                    rem_nxt  = rem_sh - trial;
                    root_nxt = {root[QW-2:0], 1'b1};
                end else begin
                    rem_nxt  = rem_sh;
                    root_nxt = {root[QW-2:0], 1'b0};
                end
                if (cnt == '0) state_nxt = ROUND;
                else           cnt_nxt   = cnt - CW'(1);
            end
            ROUND: begin
                sqrt_nxt    = {1'b0, exp_r, mant_sum[MANT_W-1:0]};
                inexact_nxt = guard | sticky;
                invalid_nxt = 1'b0;
                done_nxt    = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sqrt_fp_iterative.sv
// Scoreboard bench for sqrt_fp_iterative: f32 and f16 instances, directed vectors.
module tb_sqrt_fp_iterative;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0;
    logic        busy32, done32, inv32, inx32;
    logic [31:0] sqrt32;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic        busy16, done16, inv16, inx16;
    logic [15:0] sqrt16;

    sqrt_fp_iterative dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32),
        .busy(busy32), .done(done32), .sqrt(sqrt32),
        .invalid(inv32), .inexact(inx32)
    );

    sqrt_fp_iterative #(.EXP_W(5), .MANT_W(10)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16),
        .busy(busy16), .done(done16), .sqrt(sqrt16),
        .invalid(inv16), .inexact(inx16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb32[$];
    exp_t sb16[$];
    exp_t m32, m16;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endfunction

    // Latency is counted in edges from the edge that samples start.
    always @(negedge clk) begin
        if (!rst && done32) begin
            if (sb32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done32_spurious got sqrt=%h want no done", sqrt32);
            end else begin
                m32 = sb32.pop_front();
                chk("sqrt32", sqrt32, m32.res);
                chk("invalid32", {31'b0, inv32}, {31'b0, m32.inv});
                chk("inexact32", {31'b0, inx32}, {31'b0, m32.inx});
                chk("latency32", cyc - m32.t0, m32.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done16) begin
            if (sb16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done16_spurious got sqrt=%h want no done", sqrt16);
            end else begin
                m16 = sb16.pop_front();
                chk("sqrt16", {16'b0, sqrt16}, m16.res);
                chk("invalid16", {31'b0, inv16}, {31'b0, m16.inv});
                chk("inexact16", {31'b0, inx16}, {31'b0, m16.inx});
                chk("latency16", cyc - m16.t0, m16.lat);
            end
        end
    end

    task automatic issue32(input logic [31:0] val, input logic [31:0] res,
                           input logic inv, input logic inx, input int lat);
        exp_t e;
        e.res = res; e.inv = inv; e.inx = inx; e.lat = lat; e.t0 = cyc + 1;
        sb32.push_back(e);
        a32 = val;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        a32 = 32'hDEADBEEF;
    endtask

    task automatic issue16(input logic [15:0] val, input logic [15:0] res,
                           input logic inv, input logic inx, input int lat);
        exp_t e;
        e.res = {16'b0, res}; e.inv = inv; e.inx = inx; e.lat = lat; e.t0 = cyc + 1;
        sb16.push_back(e);
        a16 = val;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'hBEEF;
    endtask

    task automatic wait_done32(output int bcnt);
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (done32) return;
            if (busy32) bcnt++;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL done32_timeout got no done want done within 200 cycles");
    endtask

    task automatic wait_done16(output int bcnt);
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (done16) return;
            if (busy16) bcnt++;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL done16_timeout got no done want done within 200 cycles");
    endtask

    task automatic run32(input logic [31:0] val, input logic [31:0] res,
                         input logic inv, input logic inx, input bit special);
        int b;
        issue32(val, res, inv, inx, special ? 0 : 26);
        wait_done32(b);
        chk("busy32_cycles", b, special ? 0 : 25);
        @(negedge clk);
    endtask

    task automatic run16(input logic [15:0] val, input logic [15:0] res,
                         input logic inv, input logic inx);
        int b;
        issue16(val, res, inv, inx, 13);
        wait_done16(b);
        chk("busy16_cycles", b, 12);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        int b;
        #3 rst = 1'b1;
        #2;
        chk("reset_sqrt32", sqrt32, 32'h0);
        chk("reset_flags32", {28'b0, busy32, done32, inv32, inx32}, 32'h0);
        chk("reset_sqrt16", {16'b0, sqrt16}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Normal f32 operands, including a negative odd exponent
        run32(32'h40800000, 32'h40000000, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("sqrt32_held", sqrt32, 32'h40000000);
        run32(32'h40000000, 32'h3FB504F3, 1'b0, 1'b1, 1'b0);
        run32(32'h3F000000, 32'h3F3504F3, 1'b0, 1'b1, 1'b0);
        run32(32'h3E800000, 32'h3F000000, 1'b0, 1'b0, 1'b0);

        // Special operands complete in the cycle after the request
        run32(32'hBF800000, 32'h7FC00000, 1'b1, 1'b0, 1'b1);
        run32(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1);
        run32(32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1);
        run32(32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 1'b1);
        run32(32'h7F800001, 32'h7FC00000, 1'b1, 1'b0, 1'b1);
        run32(32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
        run32(32'hFF800000, 32'h7FC00000, 1'b1, 1'b0, 1'b1);

        // Half precision instance
        run16(16'h4880, 16'h4200, 1'b0, 1'b0);
        run16(16'h3C00, 16'h3C00, 1'b0, 1'b0);

        // Start while busy is dropped; start in the done cycle is accepted
        issue32(32'h40800000, 32'h40000000, 1'b0, 1'b0, 26);
        repeat (4) @(negedge clk);
        a32 = 32'h41100000;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wait_done32(b);
        issue32(32'h41100000, 32'h40400000, 1'b0, 1'b0, 26);
        wait_done32(b);
        chk("busy32_cycles_b2b", b, 25);
        repeat (3) @(negedge clk);
        chk("sqrt32_held_b2b", sqrt32, 32'h40400000);

        // Reset in the middle of an iteration aborts without a done pulse
        issue32(32'h40800000, 32'h40000000, 1'b0, 1'b0, 26);
        repeat (9) @(negedge clk);
        chk("busy32_before_reset", {31'b0, busy32}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("abort_sqrt32", sqrt32, 32'h0);
        chk("abort_flags32", {28'b0, busy32, done32, inv32, inx32}, 32'h0);
        sb32.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        run32(32'h40800000, 32'h40000000, 1'b0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb32.size() + sb16.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt_fp_iterative.md
Name: sqrt_fp_iterative

Overview:
- Parametrised IEEE-754-style floating-point square root with a start/busy/done handshake.
- Computes one result bit per cycle using a restoring digit-by-digit integer root on the significand, then rounds to nearest-even.
- Successor to the f32-only divide/mean approximation root: any exponent/mantissa width, deterministic latency, full special-case handling and exception flags.
- Sits in the processing-element datapath beside the FP divide/mean blocks.

Parameters:
- EXP_W, 8, exponent field width. BIAS = 2^(EXP_W-1)-1 and W = 1+EXP_W+MANT_W are derived localparams.
- MANT_W, 23, stored fraction width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only when state==IDLE.
- a  in  W  operand; latched on an accepted start.
- busy  out  1  high while the iterative path is in progress.
- done  out  1  one-cycle pulse; sqrt and flags valid from this cycle on.
- sqrt  out  W  result; held until the next result is written.
- invalid  out  1  invalid-operation flag; qualified by done, held with sqrt.
- inexact  out  1  result rounded (guard or sticky nonzero); held with sqrt.

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, sqrt=0, invalid=0, inexact=0; all datapath registers cleared. Reset mid-iteration aborts the operation with no done pulse.
- States: IDLE, ITER, ROUND.
- IDLE + start, operand classified in the same cycle:
  - Special operand: at the next edge write sqrt/flags, pulse done, stay IDLE. Latency 1, busy never asserts.
  - Normal operand: go to ITER, busy=1.
- Special cases, with s = sign of a:
  - exp==0 (zero or denormal, denormals flushed) -> {s,0...}; no flags.
  - s=1 and nonzero (includes -inf) -> canonical qNaN {0, all-ones exp, 1, zeros}; invalid=1.
  - +inf -> +inf; no flags.
  - NaN -> canonical qNaN; invalid=1 only if signalling (fraction MSB=0).
- Normal path setup:
  - m = {1,frac} (MANT_W+1 bits); e = exp-BIAS.
  - e even: R = m<<(MANT_W+2); result exponent field = e/2+BIAS.
  - e odd: R = m<<(MANT_W+3); result exponent field = ((e-1)>>>1)+BIAS, an arithmetic shift; negative odd e must floor.
  - R is 2*(MANT_W+2) bits. rem (MANT_W+4 bits) and q (MANT_W+2 bits) are cleared.
- ITER, exactly MANT_W+2 cycles (counter counts down, no wrap):
  - rem' = {rem, top 2 bits of R}; R <<= 2; trial = {q,2'b01}.
  - If rem' >= trial: rem = rem'-trial, q = {q,1}. Else rem = rem', q = {q,0}.
  - After the final iteration, go to ROUND.
- ROUND, 1 cycle:
  - guard = q[0]; sticky = (rem != 0); up = guard & (sticky | q[1]).
  - mant = q[MANT_W:1] + up. A carry out zeroes the mantissa and increments the exponent.
  - Write sqrt = {s=0, exp, mant}; inexact = guard|sticky; invalid=0.
  - done=1 for one cycle, busy=0, state=IDLE.
- Normal latency: start accepted at edge t0 -> done high after edge t0+MANT_W+3 (26 cycles for f32).
- start while busy: ignored, no queuing.
- start in the done cycle: accepted (state is IDLE); the previous sqrt stays valid until overwritten.
- a may change after acceptance without effect.

Test Plan:
- f32, a=0x40800000 (4.0) -> sqrt=0x40000000, inexact=0, invalid=0; done exactly 26 cycles after the start edge; busy high 25 cycles.
- f32, a=0x40000000 (2.0) -> 0x3FB504F3, inexact=1. a=0x3F000000 (0.5, odd negative e) -> 0x3F3504F3. a=0x3E800000 (0.25) -> 0x3F000000.
- f32 specials:
  - 0xBF800000 -> 0x7FC00000, invalid=1.
  - 0x80000000 -> 0x80000000.
  - 0x00000001 -> 0x00000000.
  - 0x7F800000 -> 0x7F800000.
  - 0x7F800001 -> 0x7FC00000, invalid=1.
  - 0x7FC00000 -> 0x7FC00000, invalid=0.
  - All specials: done 1 cycle after start, busy=0.
- start pulsed at cycle 5 of a 4.0 operation with a=0x41100000 -> ignored, result 0x40000000. Back-to-back start in the done cycle with 9.0 (0x41100000) -> 0x40400000 after 26 more cycles.
- rst asserted at iteration 10 -> busy, done, sqrt, flags go to 0 immediately, no done pulse. A subsequent 4.0 request completes normally.
- EXP_W=5, MANT_W=10: a=0x4880 (9.0) -> 0x4200 (3.0), latency 13. a=0x3C00 (1.0) -> 0x3C00, inexact=0.
